pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath; successor to the fixed 8-bit single-cycle lookahead adder. The operand width is split into lookahead groups of BLOCK bits, with one group resolved per pipeline stage and a registered group carry between stages. The block accepts one operation per cycle under a valid/ready handshake and returns the sum, carry-out and the signed comparison flags the ALU needs.

## Interface
- WIDTH, 32: operand/result width; must be a positive multiple of BLOCK (elaboration error otherwise).
- BLOCK, 8: lookahead group width; NSTAGE = WIDTH/BLOCK pipeline stages.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- data_operandA  in  WIDTH  operand A.
- data_operandB  in  WIDTH  operand B.
- ctrl_sub  in  1  1 = A − B, 0 = A + B.
- cin  in  1  carry-in for add; ignored when ctrl_sub = 1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- data_result  out  WIDTH  sum/difference modulo 2^WIDTH.
- cout  out  1  carry out of MSB.
- overflow  out  1  signed overflow.
- isNotEqual  out  1  sub only: A ≠ B.
- isLessThan  out  1  sub only: signed A < B.

## Operation
- Effective B = ctrl_sub ? ~B : B; effective carry-in c0 = ctrl_sub ? 1 : cin.
- Per bit g = a&b, p = a|b; within a group every carry is a full lookahead expansion of g/p and group carry-in (no ripple inside a group); sum bit = a^b^c.
- Stage k (0..NSTAGE−1) computes group k from its registered carry-in, registers group k sum bits and carry out. Groups k+1.. of the operands and ctrl_sub travel in skew registers alongside.
- Pipeline advances as a whole: advance = !out_valid | out_ready; in_ready = advance. Each stage has a valid bit; bubbles are carried, not collapsed.
- Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge.
- overflow = carry into MSB ^ cout. isNotEqual = ctrl_sub & (result ≠ 0). isLessThan = ctrl_sub & (result[MSB] ^ overflow). For add both are 0.
- Outputs held stable while out_valid & !out_ready.

## Timing
- Latency: operation accepted at edge t appears with out_valid high after edge t+NSTAGE−1 (NSTAGE edges incl. the accept edge); throughput 1/cycle without backpressure.
- NSTAGE = 1 degenerates to a registered single-cycle lookahead adder.
- Reset (reset_n = 0 at an edge): all valid bits 0; out_valid 0; data_result, cout, overflow, isNotEqual, isLessThan all 0; in_ready 1 in the cycle after reset. Reset mid-operation discards every in-flight operation; no partial result emerges.
- in_valid with in_ready = 0: not accepted; operands must be held by source.
- Simultaneous accept and deliver in one cycle is legal and keeps full throughput.
- Wrap-around: results are modulo 2^WIDTH; cout reports the lost bit.

## Configuration
- PIPE_CLA_FLAGS_EN defined: overflow, isNotEqual, isLessThan computed as above and pipelined with the result.
- Undefined: the three flag outputs are tied 0 and their logic/registers are not built; data_result, cout and handshake unchanged.

## Test plan
- WIDTH=32, BLOCK=8, add 0x0000_00FF + 0x0000_0001, cin=0 -> data_result 0x0000_0100, cout 0, out_valid exactly 4 edges after accept.
- Add 0x7FFF_FFFF + 0x0000_0001 -> 0x8000_0000, overflow 1, cout 0; add 0xFFFF_FFFF + 0 with cin=1 -> 0x0000_0000, cout 1, overflow 0.
- Sub 5 − 7 -> 0xFFFF_FFFE, isLessThan 1, isNotEqual 1, cout 0; sub 7 − 7 -> 0, isNotEqual 0, isLessThan 0, cout 1.
- Stream 8 back-to-back ops with out_ready=1 -> 8 results in order on 8 consecutive cycles; hold out_ready=0 for 3 cycles mid-stream -> in_ready 0 while out_valid, no result lost or duplicated.
- Assert reset_n=0 for one edge with 3 ops in flight -> out_valid 0 and all outputs 0 next cycle; no stale result afterwards.
- WIDTH=8, BLOCK=8: add 0xFF + 0x01 -> 0x00, cout 1, 1-cycle latency; repeat compiled without PIPE_CLA_FLAGS_EN -> flags stay 0.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage.
// Define PIPE_CLA_FLAGS_EN to build the overflow / isNotEqual / isLessThan flag path.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan
);
    localparam int unsigned NSTAGE = (BLOCK == 0) ? 1 : WIDTH / BLOCK;

    if (BLOCK == 0 || WIDTH == 0 || (WIDTH % BLOCK) != 0) begin : g_cfg_check
        $error("pipelined_cla_addsub: WIDTH must be a positive multiple of BLOCK");
    end

    // Every carry is an independent sum-of-products of g/p and the group carry-in.
    function automatic logic [BLOCK:0] group_carries(input logic [BLOCK-1:0] a,
                                                     input logic [BLOCK-1:0] b,
                                                     input logic             c0);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int unsigned j = 0; j <= i; j++) term = term & (a[j] | b[j]);
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = a[j] & b[j];
                for (int unsigned m = j + 1; m <= i; m++) term = term & (a[m] | b[m]);
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             advance;

    logic             v_q   [NSTAGE];
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic [WIDTH-1:0] s_q   [NSTAGE];
    logic             c_q   [NSTAGE];

    logic             v_d   [NSTAGE];
    logic [WIDTH-1:0] a_d   [NSTAGE];
    logic [WIDTH-1:0] b_d   [NSTAGE];
    logic [WIDTH-1:0] s_d   [NSTAGE];
    logic             c_d   [NSTAGE];

    // Slot k feeds stage k; slot 0 is the input port, slot k+1 is stage k's register.
    logic             v_in  [NSTAGE+1];
    logic [WIDTH-1:0] a_in  [NSTAGE+1];
    logic [WIDTH-1:0] b_in  [NSTAGE+1];
    logic [WIDTH-1:0] s_in  [NSTAGE+1];
    logic             c_in  [NSTAGE+1];
    logic [BLOCK:0]   car   [NSTAGE];

    assign advance     = !v_q[NSTAGE-1] || out_ready;
    assign in_ready    = advance;
    assign out_valid   = v_q[NSTAGE-1];
    assign data_result = s_q[NSTAGE-1];
    assign cout        = c_q[NSTAGE-1];

    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = data_operandA;
        b_in[0] = ctrl_sub ? ~data_operandB : data_operandB;
        s_in[0] = '0;
        c_in[0] = ctrl_sub | cin;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            v_in[k+1] = v_q[k];
            a_in[k+1] = a_q[k];
            b_in[k+1] = b_q[k];
            s_in[k+1] = s_q[k];
            c_in[k+1] = c_q[k];
        end
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            car[k] = group_carries(a_in[k][k*BLOCK +: BLOCK], b_in[k][k*BLOCK +: BLOCK], c_in[k]);
            s_d[k] = s_in[k];
            s_d[k][k*BLOCK +: BLOCK] = a_in[k][k*BLOCK +: BLOCK] ^ b_in[k][k*BLOCK +: BLOCK]
                                       ^ car[k][BLOCK-1:0];
            c_d[k] = car[k][BLOCK];
            v_d[k] = v_in[k];
            a_d[k] = a_in[k];
            b_d[k] = b_in[k];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

`ifdef PIPE_CLA_FLAGS_EN
    logic sub_q  [NSTAGE];
    logic sub_d  [NSTAGE];
    logic sub_in [NSTAGE+1];
    logic ovf_d, ne_d, lt_d;
    logic ovf_q, ne_q, lt_q;

    // Flags are formed as the last group resolves, so they register with the result.
    always_comb begin
        sub_in[0] = ctrl_sub;
        for (int unsigned k = 0; k < NSTAGE; k++) sub_in[k+1] = sub_q[k];
        for (int unsigned k = 0; k < NSTAGE; k++) sub_d[k] = sub_in[k];
        ovf_d = car[NSTAGE-1][BLOCK] ^ car[NSTAGE-1][BLOCK-1];
        ne_d  = sub_in[NSTAGE-1] & (s_d[NSTAGE-1] != '0);
        lt_d  = sub_in[NSTAGE-1] & (s_d[NSTAGE-1][WIDTH-1] ^ ovf_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NSTAGE; k++) sub_q[k] <= 1'b0;
            ovf_q <= 1'b0;
            ne_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < NSTAGE; k++) sub_q[k] <= sub_d[k];
            ovf_q <= ovf_d;
            ne_q  <= ne_d;
            lt_q  <= lt_d;
        end
    end

    assign overflow   = ovf_q;
    assign isNotEqual = ne_q;
    assign isLessThan = lt_q;
`else
    assign overflow   = 1'b0;
    assign isNotEqual = 1'b0;
    assign isLessThan = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: a 32/8 instance and an 8/8 instance against an arithmetic model.
module tb_pipelined_cla_addsub;
    localparam int unsigned NS0 = 4;
    localparam int unsigned NS1 = 1;

`ifdef PIPE_CLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        of;
        logic        ne;
        logic        lt;
        int unsigned acc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv   [2];
    logic        ordy [2];
    logic        sub  [2];
    logic        ci   [2];
    logic [31:0] opa  [2];
    logic [31:0] opb  [2];
    logic        ir0, ov0, co0, of0, ne0, lt0;
    logic        ir1, ov1, co1, of1, ne1, lt1;
    logic [31:0] r0;
    logic [7:0]  r1;

    int          total  = 0;
    int          bad    = 0;
    int unsigned ecount = 0;
    bit          exact_lat = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .data_operandA(opa[0]), .data_operandB(opb[0]), .ctrl_sub(sub[0]), .cin(ci[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .data_result(r0), .cout(co0),
        .overflow(of0), .isNotEqual(ne0), .isLessThan(lt0)
    );

    pipelined_cla_addsub #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .data_operandA(opa[1][7:0]), .data_operandB(opb[1][7:0]), .ctrl_sub(sub[1]), .cin(ci[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .data_result(r1), .cout(co1),
        .overflow(of1), .isNotEqual(ne1), .isLessThan(lt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Exact integer arithmetic: unsigned sum for result/cout, signed sum for overflow.
    function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic c);
        exp_t   e;
        longint span, half, ua, ub, sa, sb, full, sx;
        span  = longint'(1) << w;
        half  = span / 2;
        ua    = longint'({32'd0, a}) & (span - 1);
        ub    = longint'({32'd0, b}) & (span - 1);
        sa    = (ua >= half) ? ua - span : ua;
        sb    = (ub >= half) ? ub - span : ub;
        full  = s ? ua - ub : ua + ub + longint'(c);
        sx    = s ? sa - sb : sa + sb + longint'(c);
        e.res = 32'(full & (span - 1));
        e.co  = s ? (ua >= ub) : (full >= span);
        e.of  = FLAGS & ((sx >= half) || (sx < -half));
        e.ne  = FLAGS & s & (ua != ub);
        e.lt  = FLAGS & s & (sa < sb);
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0080;
            5:       return 32'h0000_007F;
            default: return $urandom();
        endcase
    endfunction

    task automatic step(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic rdy, output logic acc);
        logic        irdy, ovld, oc, oo, on, ol;
        logic [31:0] ores;
        exp_t        e;
        int unsigned nst;
        iv[d] = v; opa[d] = a; opb[d] = b; sub[d] = s; ci[d] = c; ordy[d] = rdy;
        #1;
        if (d == 0) begin
            irdy = ir0; ovld = ov0; ores = r0; oc = co0; oo = of0; on = ne0; ol = lt0; nst = NS0;
        end else begin
            irdy = ir1; ovld = ov1; ores = {24'd0, r1}; oc = co1; oo = of1; on = ne1; ol = lt1; nst = NS1;
        end
        acc = 1'b0;
        if (rst_n) begin
            chk("in_ready", irdy, !ovld || rdy);
            if (ovld && rdy) begin
                chk("no_stray_result", ((d == 0) ? q0.size() : q1.size()) != 0, 1'b1);
                if ((d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("result", ores, e.res);
                    chk("cout", oc, e.co);
                    chk("overflow", oo, e.of);
                    chk("isNotEqual", on, e.ne);
                    chk("isLessThan", ol, e.lt);
                    if (exact_lat) chk("latency", ecount - e.acc, nst - 1);
                end
            end
            if (v && irdy) begin
                e     = model((d == 0) ? 32 : 8, a, b, s, c);
                e.acc = ecount + 1;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(d, 1'b1, a, b, s, c, 1'b1, acc);
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 40; i++) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) break;
            idle(d, 1);
        end
        chk("drain_empty", (d == 0) ? q0.size() : q1.size(), 0);
        idle(d, 2);
    endtask

    task automatic check_idle(input int d);
        if (d == 0) begin
            chk("rst_out_valid", ov0, 0); chk("rst_result", r0, 0); chk("rst_cout", co0, 0);
            chk("rst_overflow", of0, 0); chk("rst_isNotEqual", ne0, 0); chk("rst_isLessThan", lt0, 0);
            chk("rst_in_ready", ir0, 1);
        end else begin
            chk("rst_out_valid8", ov1, 0); chk("rst_result8", {24'd0, r1}, 0); chk("rst_cout8", co1, 0);
            chk("rst_overflow8", of1, 0); chk("rst_isNotEqual8", ne1, 0); chk("rst_isLessThan8", lt1, 0);
            chk("rst_in_ready8", ir1, 1);
        end
    endtask

    task automatic mixed(input int d, input int cycles);
        logic        pend, acc, rdy, s, c;
        logic [31:0] a, b;
        pend = 1'b0; a = '0; b = '0; s = 1'b0; c = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                a    = pick();
                b    = ($urandom_range(0, 5) == 0) ? a : pick();
                s    = 1'($urandom_range(0, 1));
                c    = 1'($urandom_range(0, 1));
            end
            rdy = ($urandom_range(0, 3) != 0);
            step(d, pend, a, b, s, c, rdy, acc);
            if (acc) pend = 1'b0;
        end
        drain(d);
    endtask

    initial begin
        logic        acc, rdy;
        int          sent;
        logic [31:0] ta [10];
        logic [31:0] tb [10];
        logic        ts [10];
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; sub[i] = 1'b0; ci[i] = 1'b0; opa[i] = '0; opb[i] = '0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        idle(0, 2);
        check_idle(0);
        check_idle(1);
        rst_n = 1'b1;

        exact_lat = 1'b1;
        send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); drain(0);
        send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain(0);
        send(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1); drain(0);
        send(0, 32'd5, 32'd7, 1'b1, 1'b0);                 drain(0);
        send(0, 32'd7, 32'd7, 1'b1, 1'b1);                 drain(0);
        send(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0); drain(0);

        for (int i = 0; i < 8; i++) send(0, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(0);

        exact_lat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ta[i] = pick(); tb[i] = pick(); ts[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        for (int i = 0; i < 40 && sent < 10; i++) begin
            rdy = !(i >= 5 && i < 8);
            step(0, 1'b1, ta[sent], tb[sent], ts[sent], 1'b0, rdy, acc);
            if (acc) sent++;
        end
        chk("stall_sent", sent, 10);
        drain(0);

        mixed(0, 80);

        exact_lat = 1'b1;
        for (int i = 0; i < 3; i++) send(0, pick(), pick(), 1'b0, 1'b1);
        rst_n = 1'b0;
        idle(0, 1);
        check_idle(0);
        q0.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stale_valid", ov0, 0);
            idle(0, 1);
        end

        send(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); drain(1);
        send(1, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0); drain(1);
        send(1, 32'd5, 32'd7, 1'b1, 1'b0);                 drain(1);
        send(1, 32'd7, 32'd7, 1'b1, 1'b0);                 drain(1);
        for (int i = 0; i < 6; i++) send(1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(1);
        exact_lat = 1'b0;
        mixed(1, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
